muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Multi-cycle multiply/divide sequencer and HI/LO register owner for the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the ALU decode and stalls the pipeline while the operation runs. Division uses an iterative radix-2 core, multiplication a fixed-latency path. Results commit to HI/LO exactly once, and a pipeline flush cancels the operation cleanly.

## Interface
- MUL_LAT, 1: cycles spent in MUL state (legal 1..4)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- op_valid  in  1  EX stage holds a valid instruction for this block
- op  in  5  ALU op code (`ALU_MULT`, `ALU_MULTU`, `ALU_DIV`, `ALU_DIVU`, `ALU_MTHI`, `ALU_MTLO`); other codes ignored
- a, b  in  32 each  operands (rs, rt)
- flush  in  1  pipeline flush/exception; cancels in-flight op
- stall  out  1  hold EX and earlier stages
- done  out  1  one-cycle pulse on HI/LO commit of mult/div
- hi_o, lo_o  out  32 each  registered HI/LO values, read by MFHI/MFLO

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE, op_valid & !flush:
  - MTHI/MTLO: write a into HI/LO at the clock edge; no stall; stay IDLE.
  - MULT/MULTU: latch operands and signedness; stall=1; go to MUL.
  - DIV/DIVU: latch operands and signedness; stall=1; go to DIV.
- MUL: counter runs MUL_LAT cycles, then DONE. Product is 64-bit: signed for MULT, zero-extended for MULTU. hi=[63:32], lo=[31:0].
- DIV: 32 iteration cycles on operand magnitudes (counter 0..31), then DONE.
  - Signed: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - lo=quotient, hi=remainder.
- DONE: stall=0, done=1; HI/LO written at the clock edge ending DONE; go to IDLE. The instruction leaves EX in this cycle, so it is not re-accepted.
- Divide by zero (latched b==0): full latency; hi=a, lo=0xFFFFFFFF for both DIV and DIVU.
- 0x80000000 / 0xFFFFFFFF signed: lo=0x80000000, hi=0 (wraps, no trap).
- flush in any state:
  - stall=0 combinationally and done=0.
  - No HI/LO write, including from DONE or an IDLE MTHI/MTLO.
  - Next state IDLE; the core is cleared.
- stall = (IDLE & op_valid & !flush & op is mult/div) | ((MUL | DIV) & !flush).

## Timing
- Reset (asynchronous, immediate): state IDLE, hi_o=0, lo_o=0, stall=0, done=0, counters 0. Reset mid-operation discards the operation.
- Accept cycle T: stall=1.
- DIV/DIVU: stall high T..T+32 (33 cycles); DONE at T+33; hi_o/lo_o new from T+34.
- MULT/MULTU: stall high T..T+MUL_LAT; DONE at T+MUL_LAT+1.
- MTHI/MTLO at T: visible on hi_o/lo_o at T+1.
- No internal forwarding: an MFHI in the cycle of a commit reads the old value. Hazard handling lives upstream.
- Back-to-back ops: a new op is accepted in the first IDLE cycle after DONE or after a flush.

## Structure
- Op codes come from the shared `aludefines.vh`.
- Package `muldiv_pkg` holds:
  - state enum `muldiv_state_t` (IDLE, MUL, DIV, DONE)
  - constant `DIV_ITERS = 32`
  - divide-by-zero result constant `DIV0_LO = 32'hFFFFFFFF`
- Sub-module `div_iter`: unsigned 32/32 restoring divider with start/clear inputs and a 32-cycle done. Sign handling and the divide-by-zero override stay in `muldiv_ctrl`.
- The multiply is a registered 64-bit product inside `muldiv_ctrl`.

## Test plan
- DIVU a=100, b=7 → stall high exactly 33 cycles, done pulse, then hi_o=2, lo_o=14.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1).
- With MUL_LAT=1:
  - MULT a=0xFFFFFFFF, b=2 → stall 2 cycles, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE.
  - MULTU with the same operands → hi_o=1, lo_o=0xFFFFFFFE.
- DIVU 100/7 with flush at iteration 10 → stall low that cycle, HI/LO unchanged, no done pulse. A DIVU 9/3 issued next cycle → lo_o=3, hi_o=0.
- DIV a=5, b=0 → after 33 stall cycles hi_o=5, lo_o=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo_o=0x80000000, hi_o=0.
- MTHI a=0x1234 → hi_o=0x1234 next cycle. Then assert rst low mid-DIV → hi_o=0, lo_o=0, stall=0 before the next clock edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage multiply/divide sequencer.
// The ALU op codes mirror the values in the shared ALU decode definitions.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    localparam int          DIV_ITERS = 32;
    localparam logic [31:0] DIV0_LO   = 32'hFFFF_FFFF;

    localparam logic [4:0] ALU_MULT  = 5'd16;
    localparam logic [4:0] ALU_MULTU = 5'd17;
    localparam logic [4:0] ALU_DIV   = 5'd18;
    localparam logic [4:0] ALU_DIVU  = 5'd19;
    localparam logic [4:0] ALU_MTHI  = 5'd20;
    localparam logic [4:0] ALU_MTLO  = 5'd21;

    // Magnitude of a 32-bit operand; only negative values of signed ops are negated.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Unsigned 32/32 restoring divider: one quotient bit per cycle, 32 cycles after start.
// done_o is high during the final iteration cycle; results are stable the cycle after.
module div_iter
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        clear_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        done_o
);

    logic        busy_q;
    logic [4:0]  cnt_q;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dvs_q;
    logic [32:0] shifted;
    logic [32:0] diff;

    // Bit 32 of diff is the borrow: set means the trial subtraction is undone.
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else if (clear_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            quo_q  <= dividend_i;
            rem_q  <= '0;
            dvs_q  <= divisor_i;
        end else if (busy_q) begin
            if (!diff[32]) begin
                rem_q <= diff[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= shifted[31:0];
                quo_q <= {quo_q[30:0], 1'b0};
            end
            cnt_q <= cnt_q + 5'd1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done_o      = busy_q && (cnt_q == 5'(DIV_ITERS - 1));
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer owning HI/LO: stalls EX while a MULT/DIV runs and
// commits the result once in DONE; flush drops everything including MTHI/MTLO.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [4:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    muldiv_state_t state_q, state_d;
    logic [1:0]    mul_cnt_q, mul_cnt_d;
    logic [31:0]   a_q, b_q, hi_q, lo_q, hi_d, lo_d;
    logic          signed_q, is_div_q;
    logic [63:0]   prod_q, prod, a_ext, b_ext;
    logic          is_mul_op, is_div_op, op_signed;
    logic          load_op, div_start, div_clear, div_done, hi_we, lo_we;
    logic [31:0]   div_quo, div_rem, quo_fix, rem_fix;

    assign is_mul_op = (op == ALU_MULT) || (op == ALU_MULTU);
    assign is_div_op = (op == ALU_DIV)  || (op == ALU_DIVU);
    assign op_signed = (op == ALU_MULT) || (op == ALU_DIV);

    div_iter u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .clear_i    (div_clear),
        .dividend_i (mag32(a, op_signed)),
        .divisor_i  (mag32(b, op_signed)),
        .quotient_o (div_quo),
        .remainder_o(div_rem),
        .done_o     (div_done)
    );

    // One 64x64 multiplier serves both signednesses via the operand extension.
    assign a_ext = {{32{signed_q & a_q[31]}}, a_q};
    assign b_ext = {{32{signed_q & b_q[31]}}, b_q};
    assign prod  = a_ext * b_ext;

    assign quo_fix = (signed_q && (a_q[31] ^ b_q[31])) ? (~div_quo + 32'd1) : div_quo;
    assign rem_fix = (signed_q && a_q[31]) ? (~div_rem + 32'd1) : div_rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        if (flush) begin
            state_d   = IDLE;
            mul_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (op_valid && is_mul_op) begin
                        state_d   = MUL;
                        mul_cnt_d = '0;
                    end else if (op_valid && is_div_op) begin
                        state_d = DIV;
                    end
                end
                MUL: begin
                    if (mul_cnt_q == 2'(MUL_LAT - 1)) begin
                        state_d   = DONE;
                        mul_cnt_d = '0;
                    end else begin
                        mul_cnt_d = mul_cnt_q + 2'd1;
                    end
                end
                DIV:     if (div_done) state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        stall     = 1'b0;
        done      = 1'b0;
        load_op   = 1'b0;
        div_start = 1'b0;
        div_clear = flush;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (rst && !flush) begin
            case (state_q)
                IDLE: begin
                    if (op_valid) begin
                        stall     = is_mul_op || is_div_op;
                        load_op   = is_mul_op || is_div_op;
                        div_start = is_div_op;
                        hi_we     = (op == ALU_MTHI);
                        lo_we     = (op == ALU_MTLO);
                        hi_d      = a;
                        lo_d      = a;
                    end
                end
                MUL, DIV: stall = 1'b1;
                default: begin
                    done  = 1'b1;
                    hi_we = 1'b1;
                    lo_we = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod_q[63:32];
                        lo_d = prod_q[31:0];
                    end else if (b_q == 32'd0) begin
                        hi_d = a_q;
                        lo_d = DIV0_LO;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            is_div_q <= 1'b0;
            prod_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            if (load_op) begin
                a_q      <= a;
                b_q      <= b;
                signed_q <= op_signed;
                is_div_q <= is_div_op;
            end
            if (state_q == MUL) prod_q <= prod;
            if (hi_we) hi_q <= hi_d;
            if (lo_we) lo_q <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, randomized ops
// against an arithmetic reference model, and an asynchronous reset corner.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int TB_MUL_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic [4:0]  op = 5'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        stall, done;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;

    muldiv_ctrl #(.MUL_LAT(TB_MUL_LAT)) dut (
        .clk     (clk),
        .rst     (rst),
        .op_valid(op_valid),
        .op      (op),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .stall   (stall),
        .done    (done),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          flush_at;
        logic [31:0] hi;
        logic [31:0] lo;
        int          stall;
        bit          done;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller is at posedge+1; returns at posedge+1 of the cycle after the op left EX.
    task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int flush_at, input logic [31:0] old_hi, input logic [31:0] old_lo,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int exp_stall, input bit exp_done);
        int stall_cnt = 0;
        int done_cnt  = 0;
        bit fin       = 1'b0;
        op_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        for (int c = 0; c < 80 && !fin; c++) begin
            flush = (c == flush_at);
            @(negedge clk);
            if (stall) stall_cnt++;
            if (done)  done_cnt++;
            if (!stall) begin
                fin = 1'b1;
                check("hi_before_commit", hi_o, old_hi);
                check("lo_before_commit", lo_o, old_lo);
            end
            @(posedge clk);
            #1;
        end
        op_valid = 1'b0;
        flush    = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL timeout: stall still high after 80 cycles, expected low after %0d", exp_stall);
        end
        check("stall_cycles", stall_cnt, exp_stall);
        check("done_pulses", done_cnt, exp_done ? 1 : 0);
        check("hi_o", hi_o, exp_hi);
        check("lo_o", lo_o, exp_lo);
        $display("txn op=%0d a=%h b=%h flush_at=%0d stall=%0d done=%0d hi=%h lo=%h",
                 o, x, y, flush_at, stall_cnt, done_cnt, hi_o, lo_o);
    endtask

    // Result of an op computed straight from the arithmetic definition.
    task automatic ref_model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] h0, input logic [31:0] l0,
                             output logic [31:0] h, output logic [31:0] l, output int lat);
        logic [63:0] p;
        longint      sx, sy, q, r;
        h   = h0;
        l   = l0;
        lat = 0;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        case (o)
            ALU_MULT: begin
                p = sx * sy;
                h = p[63:32]; l = p[31:0]; lat = TB_MUL_LAT + 1;
            end
            ALU_MULTU: begin
                p = {32'd0, x} * {32'd0, y};
                h = p[63:32]; l = p[31:0]; lat = TB_MUL_LAT + 1;
            end
            ALU_DIV, ALU_DIVU: begin
                lat = 33;
                if (y == 32'd0) begin
                    h = x; l = 32'hFFFF_FFFF;
                end else if (o == ALU_DIVU) begin
                    h = x % y; l = x / y;
                end else begin
                    q = sx / sy; r = sx % sy;
                    p = q; l = p[31:0];
                    p = r; h = p[31:0];
                end
            end
            ALU_MTHI: h = x;
            ALU_MTLO: l = x;
            default: ;
        endcase
    endtask

    initial begin
        logic [31:0] hi_m, lo_m, nh, nl;
        logic [4:0]  ops [6];
        logic [4:0]  o;
        logic [31:0] x, y;
        int          lat, fa;

        tbl[0]  = '{ALU_DIVU,  32'd100,        32'd7,          -1, 32'd2,          32'd14,         33, 1'b1};
        tbl[1]  = '{ALU_DIV,   32'hFFFF_FFF9,  32'd2,          -1, 32'hFFFF_FFFF,  32'hFFFF_FFFD,  33, 1'b1};
        tbl[2]  = '{ALU_MULT,  32'hFFFF_FFFF,  32'd2,          -1, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  2,  1'b1};
        tbl[3]  = '{ALU_MULTU, 32'hFFFF_FFFF,  32'd2,          -1, 32'd1,          32'hFFFF_FFFE,  2,  1'b1};
        tbl[4]  = '{ALU_DIVU,  32'd100,        32'd7,          11, 32'd1,          32'hFFFF_FFFE,  11, 1'b0};
        tbl[5]  = '{ALU_DIVU,  32'd9,          32'd3,          -1, 32'd0,          32'd3,          33, 1'b1};
        tbl[6]  = '{ALU_DIV,   32'd5,          32'd0,          -1, 32'd5,          32'hFFFF_FFFF,  33, 1'b1};
        tbl[7]  = '{ALU_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  -1, 32'd0,          32'h8000_0000,  33, 1'b1};
        tbl[8]  = '{ALU_MTHI,  32'h1234,       32'd0,          -1, 32'h1234,       32'h8000_0000,  0,  1'b0};
        tbl[9]  = '{ALU_MTLO,  32'hCAFE,       32'd0,          -1, 32'h1234,       32'hCAFE,       0,  1'b0};
        tbl[10] = '{ALU_DIVU,  32'd7,          32'd0,          -1, 32'd7,          32'hFFFF_FFFF,  33, 1'b1};
        tbl[11] = '{ALU_MTHI,  32'h5555,       32'd0,          0,  32'd7,          32'hFFFF_FFFF,  0,  1'b0};
        tbl[12] = '{ALU_MULT,  32'd3,          32'd4,          1,  32'd7,          32'hFFFF_FFFF,  1,  1'b0};
        tbl[13] = '{ALU_MULT,  32'd3,          32'd4,          2,  32'd7,          32'hFFFF_FFFF,  2,  1'b0};
        tbl[14] = '{5'd0,      32'd99,         32'd1,          -1, 32'd7,          32'hFFFF_FFFF,  0,  1'b0};
        tbl[15] = '{ALU_MULT,  32'h8000_0000,  32'h8000_0000,  -1, 32'h4000_0000,  32'd0,          2,  1'b1};
        tbl[16] = '{ALU_DIV,   32'd7,          32'hFFFF_FFFE,  -1, 32'd1,          32'hFFFF_FFFD,  33, 1'b1};

        ops[0] = ALU_MULT; ops[1] = ALU_MULTU; ops[2] = ALU_DIV;
        ops[3] = ALU_DIVU; ops[4] = ALU_MTHI;  ops[5] = ALU_MTLO;

        #12;
        check("reset_hi", hi_o, 32'd0);
        check("reset_lo", lo_o, 32'd0);
        check("reset_stall", stall, 1'b0);
        check("reset_done", done, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        hi_m = 32'd0;
        lo_m = 32'd0;
        for (int i = 0; i < 17; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].flush_at, hi_m, lo_m,
                   tbl[i].hi, tbl[i].lo, tbl[i].stall, tbl[i].done);
            hi_m = tbl[i].hi;
            lo_m = tbl[i].lo;
        end

        for (int i = 0; i < 40; i++) begin
            o = ops[$urandom_range(0, 5)];
            x = $urandom();
            y = $urandom();
            if ($urandom_range(0, 7) == 0) y = 32'd0;
            if ($urandom_range(0, 7) == 0) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(1, 31);
            ref_model(o, x, y, hi_m, lo_m, nh, nl, lat);
            fa = ($urandom_range(0, 4) == 0) ? $urandom_range(0, lat) : -1;
            if (fa >= 0) begin
                run_op(o, x, y, fa, hi_m, lo_m, hi_m, lo_m, fa, 1'b0);
            end else begin
                run_op(o, x, y, -1, hi_m, lo_m, nh, nl, lat, lat != 0);
                hi_m = nh;
                lo_m = nl;
            end
        end

        // MTHI, then an asynchronous reset in the middle of a divide.
        run_op(ALU_MTHI, 32'h1234, 32'd0, -1, hi_m, lo_m, 32'h1234, lo_m, 0, 1'b0);
        op_valid = 1'b1;
        op       = ALU_DIV;
        a        = 32'd100;
        b        = 32'd7;
        repeat (5) @(negedge clk);
        check("mid_div_stall", stall, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_hi", hi_o, 32'd0);
        check("async_reset_lo", lo_o, 32'd0);
        check("async_reset_stall", stall, 1'b0);
        op_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_op(ALU_DIVU, 32'd9, 32'd3, -1, 32'd0, 32'd0, 32'd0, 32'd3, 33, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
